// File: rtl/arb_pkg.sv
// Shared encodings and default widths for the RAM port arbiter.
package arb_pkg;

   localparam int unsigned ARB_ADDR_W       = 4;
   localparam int unsigned ARB_DATA_W       = 8;
   localparam int unsigned ARB_STREAK_W     = 3;
   localparam int unsigned ARB_LD_BURST_MAX = 3;
   localparam int unsigned ARB_PERF_W       = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACC_CPU = 2'd1,
      ACC_LD  = 2'd2
   } arb_state_e;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_LD  = 1'b1;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the LD streak and perf counts.
module arb_sat_counter #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned MAX   = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != WIDTH'(MAX))) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port program/data RAM between the CPU and loader ports.
// Define ARB_PERF_EN to add the cpu_wait_cnt / ld_grant_cnt performance counters.
module ram_port_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = ARB_ADDR_W,
   parameter int unsigned DATA_W       = ARB_DATA_W,
   parameter int unsigned LD_BURST_MAX = ARB_LD_BURST_MAX
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [DATA_W-1:0] ld_rdata,
   input  logic              ld_lock,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
`ifdef ARB_PERF_EN
   ,
   output logic [ARB_PERF_W-1:0] cpu_wait_cnt,
   output logic [ARB_PERF_W-1:0] ld_grant_cnt
`endif
);

   arb_state_e              state_q, state_d;
   logic [ARB_STREAK_W-1:0] streak;
   logic                    streak_inc, streak_clr, streak_at_max;
   logic                    cpu_ok, acc, sel;
   logic                    cpu_rvalid_q, ld_rvalid_q;
   logic [DATA_W-1:0]       cpu_rdata_q, ld_rdata_q;

   assign cpu_ok        = cpu_req & ~ld_lock;
   assign streak_at_max = (streak == ARB_STREAK_W'(LD_BURST_MAX));

   // Winner selection happens only in IDLE; every access is a single cycle.
   always_comb begin
      state_d    = IDLE;
      streak_inc = 1'b0;
      streak_clr = 1'b0;
      case (state_q)
         IDLE: begin
            streak_clr = ~cpu_req;
            if (ld_req && !(cpu_ok && streak_at_max)) begin
               state_d    = ACC_LD;
               streak_inc = cpu_req;
            end else if (cpu_ok) begin
               state_d    = ACC_CPU;
               streak_clr = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   arb_sat_counter #(
      .WIDTH (ARB_STREAK_W),
      .MAX   (LD_BURST_MAX)
   ) u_streak (
      .clk   (clk),
      .rst   (rst),
      .inc_i (streak_inc),
      .clr_i (streak_clr),
      .cnt_o (streak)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cpu_rvalid_q <= 1'b0;
         ld_rvalid_q  <= 1'b0;
         cpu_rdata_q  <= '0;
         ld_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         cpu_rvalid_q <= cpu_gnt & ~cpu_we;
         ld_rvalid_q  <= ld_gnt & ~ld_we;
         if (cpu_rvalid_q) cpu_rdata_q <= ram_rdata;
         if (ld_rvalid_q)  ld_rdata_q  <= ram_rdata;
      end
   end

   assign cpu_gnt    = (state_q == ACC_CPU);
   assign ld_gnt     = (state_q == ACC_LD);
   assign cpu_stall  = cpu_req & ~cpu_gnt;
   assign cpu_rvalid = cpu_rvalid_q;
   assign ld_rvalid  = ld_rvalid_q;
   // RAM data arrives in the rvalid cycle, so the return path bypasses the hold register.
   assign cpu_rdata  = cpu_rvalid_q ? ram_rdata : cpu_rdata_q;
   assign ld_rdata   = ld_rvalid_q  ? ram_rdata : ld_rdata_q;

   assign acc = (state_q == ACC_CPU) || (state_q == ACC_LD);
   assign sel = (state_q == ACC_LD) ? REQ_LD : REQ_CPU;

   // Strobes are killed during reset so an interrupted access never touches RAM.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (acc) begin
         ram_en    = ~rst;
         ram_we    = ~rst & ((sel == REQ_LD) ? ld_we : cpu_we);
         ram_addr  = (sel == REQ_LD) ? ld_addr  : cpu_addr;
         ram_wdata = (sel == REQ_LD) ? ld_wdata : cpu_wdata;
      end
   end

`ifdef ARB_PERF_EN
   arb_sat_counter #(
      .WIDTH (ARB_PERF_W),
      .MAX   ((1 << ARB_PERF_W) - 1)
   ) u_cpu_wait (
      .clk   (clk),
      .rst   (rst),
      .inc_i (cpu_stall),
      .clr_i (1'b0),
      .cnt_o (cpu_wait_cnt)
   );

   arb_sat_counter #(
      .WIDTH (ARB_PERF_W),
      .MAX   ((1 << ARB_PERF_W) - 1)
   ) u_ld_grant (
      .clk   (clk),
      .rst   (rst),
      .inc_i (ld_gnt),
      .clr_i (1'b0),
      .cnt_o (ld_grant_cnt)
   );
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, cycle reference model, vector table and random traffic.
module tb_ram_port_arbiter;

   localparam int unsigned BMAX = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       cpu_req, cpu_we, ld_req, ld_we, ld_lock;
   logic [3:0] cpu_addr, ld_addr, ram_addr;
   logic [7:0] cpu_wdata, ld_wdata, ram_wdata, ram_rdata, cpu_rdata, ld_rdata;
   logic       cpu_gnt, cpu_rvalid, cpu_stall, ld_gnt, ld_rvalid, ram_en, ram_we;
`ifdef ARB_PERF_EN
   logic [15:0] cpu_wait_cnt, ld_grant_cnt;
`endif

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_W(4), .DATA_W(8), .LD_BURST_MAX(BMAX)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_lock(ld_lock),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
`ifdef ARB_PERF_EN
      , .cpu_wait_cnt(cpu_wait_cnt), .ld_grant_cnt(ld_grant_cnt)
`endif
   );

   // Synchronous-read 16x8 RAM driven only by the arbiter's strobes.
   logic [7:0] mem [16];
   logic       ram_clear;
   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
         ram_rdata <= 8'h00;
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata    <= mem[ram_addr];
      end
   end

   int n_vec = 0;
   int n_err = 0;

   // Reference model: who owns the RAM this cycle, streak length, expected memory and returns.
   int         m_grant;      // 0 none, 1 CPU, 2 LD
   int         m_streak;
   logic [7:0] shadow [16];
   logic       m_rv_c, m_rv_l;
   logic [7:0] m_rdv_c, m_rdv_l, m_hold_c, m_hold_l;
   int         m_wait, m_ldcnt;
   logic       g_cpu, g_ld;

   logic       s_cpu_gnt, s_ld_gnt, s_cpu_stall, s_ram_we, s_cpu_rvalid, s_ld_rvalid;
   logic [7:0] s_cpu_rdata;
   logic [15:0] s_wait;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Check all outputs mid-cycle against the model, then advance the model across the edge.
   task automatic cycle();
      logic       e_cg, e_lg, e_en, e_we, cpu_may;
      logic [3:0] e_addr;
      logic [7:0] e_wd;
      @(negedge clk);
      s_cpu_gnt = cpu_gnt; s_ld_gnt = ld_gnt; s_cpu_stall = cpu_stall; s_ram_we = ram_we;
      s_cpu_rvalid = cpu_rvalid; s_ld_rvalid = ld_rvalid; s_cpu_rdata = cpu_rdata;
`ifdef ARB_PERF_EN
      s_wait = cpu_wait_cnt;
`else
      s_wait = 16'h0;
`endif
      e_cg   = (m_grant == 1);
      e_lg   = (m_grant == 2);
      e_en   = (m_grant != 0) && !rst;
      e_we   = e_en && (e_cg ? cpu_we : ld_we);
      e_addr = e_cg ? cpu_addr  : (e_lg ? ld_addr  : 4'h0);
      e_wd   = e_cg ? cpu_wdata : (e_lg ? ld_wdata : 8'h00);
      chk1("cpu_gnt", cpu_gnt, e_cg);
      chk1("ld_gnt", ld_gnt, e_lg);
      chk1("cpu_stall", cpu_stall, cpu_req & ~e_cg);
      chk1("ram_en", ram_en, e_en);
      chk1("ram_we", ram_we, e_we);
      if (!((m_grant != 0) && rst)) begin
         chk4("ram_addr", ram_addr, e_addr);
         chk8("ram_wdata", ram_wdata, e_wd);
      end
      chk1("cpu_rvalid", cpu_rvalid, m_rv_c);
      chk1("ld_rvalid", ld_rvalid, m_rv_l);
      chk8("cpu_rdata", cpu_rdata, m_rv_c ? m_rdv_c : m_hold_c);
      chk8("ld_rdata", ld_rdata, m_rv_l ? m_rdv_l : m_hold_l);
`ifdef ARB_PERF_EN
      chk16("cpu_wait_cnt", cpu_wait_cnt, 16'(m_wait));
      chk16("ld_grant_cnt", ld_grant_cnt, 16'(m_ldcnt));
`endif
      g_cpu = e_cg;
      g_ld  = e_lg;
      if (rst) begin
         m_grant = 0; m_streak = 0; m_rv_c = 1'b0; m_rv_l = 1'b0;
         m_hold_c = 8'h00; m_hold_l = 8'h00; m_wait = 0; m_ldcnt = 0;
      end else begin
         if (m_rv_c) m_hold_c = m_rdv_c;
         if (m_rv_l) m_hold_l = m_rdv_l;
         m_rv_c = 1'b0;
         m_rv_l = 1'b0;
         if (e_cg) begin
            if (cpu_we) shadow[cpu_addr] = cpu_wdata;
            else begin m_rv_c = 1'b1; m_rdv_c = shadow[cpu_addr]; end
         end
         if (e_lg) begin
            if (ld_we) shadow[ld_addr] = ld_wdata;
            else begin m_rv_l = 1'b1; m_rdv_l = shadow[ld_addr]; end
         end
         if (cpu_req && !e_cg && m_wait < 65535) m_wait++;
         if (e_lg && m_ldcnt < 65535) m_ldcnt++;
         if (m_grant != 0) begin
            m_grant = 0;
         end else begin
            cpu_may = cpu_req && !ld_lock;
            if (ld_req && !(cpu_may && m_streak == BMAX)) begin
               m_grant  = 2;
               m_streak = cpu_req ? ((m_streak + 1 > BMAX) ? BMAX : m_streak + 1) : 0;
            end else if (cpu_may) begin
               m_grant  = 1;
               m_streak = 0;
            end else if (!cpu_req) begin
               m_streak = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_op(input logic we, input logic [3:0] a, input logic [7:0] d);
      logic done = 1'b0;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      for (int k = 0; k < 40 && !done; k++) begin
         cycle();
         done = g_cpu;
      end
      chk1("cpu_op_grant_in_budget", done, 1'b1);
      cpu_req = 1'b0;
   endtask

   task automatic ld_op(input logic we, input logic [3:0] a, input logic [7:0] d);
      logic done = 1'b0;
      ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d;
      for (int k = 0; k < 40 && !done; k++) begin
         cycle();
         done = g_ld;
      end
      chk1("ld_op_grant_in_budget", done, 1'b1);
      ld_req = 1'b0;
   endtask

   task automatic reset_cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   // Field order: cpu_req, ld_req, ld_lock, exp cpu_gnt, exp ld_gnt, exp cpu_stall.
   typedef struct packed {
      logic c_req, l_req, lock, e_cg, e_lg, e_cst;
   } vec_t;
   vec_t tbl [22];

   initial begin
      int cnt;
      logic prev_any, any_now, got;

      tbl[0]  = 6'b110_001; tbl[1]  = 6'b110_011; tbl[2]  = 6'b110_001; tbl[3]  = 6'b110_011;
      tbl[4]  = 6'b110_001; tbl[5]  = 6'b110_011; tbl[6]  = 6'b110_001; tbl[7]  = 6'b110_100;
      tbl[8]  = 6'b110_001; tbl[9]  = 6'b110_011; tbl[10] = 6'b111_001; tbl[11] = 6'b111_011;
      tbl[12] = 6'b111_001; tbl[13] = 6'b111_011; tbl[14] = 6'b111_001; tbl[15] = 6'b111_011;
      tbl[16] = 6'b110_001; tbl[17] = 6'b110_100; tbl[18] = 6'b101_001; tbl[19] = 6'b101_001;
      tbl[20] = 6'b100_001; tbl[21] = 6'b100_100;

      rst = 1'b1; ram_clear = 1'b1; ld_lock = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_wdata = 8'h00;
      ld_req  = 1'b0; ld_we  = 1'b0; ld_addr  = 4'h0; ld_wdata  = 8'h00;
      m_grant = 0; m_streak = 0; m_rv_c = 1'b0; m_rv_l = 1'b0;
      m_rdv_c = 8'h00; m_rdv_l = 8'h00; m_hold_c = 8'h00; m_hold_l = 8'h00;
      m_wait = 0; m_ldcnt = 0; g_cpu = 1'b0; g_ld = 1'b0;
      for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      ram_clear = 1'b0;

      cycle();
      chk1("reset_cpu_gnt", s_cpu_gnt, 1'b0);
      chk1("reset_ld_gnt", s_ld_gnt, 1'b0);
      chk1("reset_cpu_rvalid", s_cpu_rvalid, 1'b0);
      chk8("reset_cpu_rdata", s_cpu_rdata, 8'h00);
      rst = 1'b0;

      // CPU read latency after reset
      ld_op(1'b1, 4'h5, 8'h3C);
      cycle();
      reset_cycle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h5;
      cycle();
      chk1("t1_c1_stall", s_cpu_stall, 1'b1);
      chk1("t1_c1_gnt", s_cpu_gnt, 1'b0);
      cycle();
      chk1("t1_c2_gnt", s_cpu_gnt, 1'b1);
      chk1("t1_c2_stall", s_cpu_stall, 1'b0);
      cpu_req = 1'b0;
      cycle();
      chk1("t1_c3_rvalid", s_cpu_rvalid, 1'b1);
      chk8("t1_c3_rdata", s_cpu_rdata, 8'h3C);
      chk1("t1_c3_stall", s_cpu_stall, 1'b0);

      // LD write then CPU readback
      ld_op(1'b1, 4'hF, 8'hA5);
      chk1("t2_ld_ram_we", s_ram_we, 1'b1);
      cycle();
      cpu_op(1'b0, 4'hF, 8'h00);
      chk1("t2_cpu_ram_we", s_ram_we, 1'b0);
      cycle();
      chk1("t2_rvalid", s_cpu_rvalid, 1'b1);
      chk8("t2_rdata", s_cpu_rdata, 8'hA5);

      // Contended grant pattern, lock saturation and release
      reset_cycle();
      cpu_we = 1'b0; cpu_addr = 4'h0; ld_we = 1'b0; ld_addr = 4'h0;
      for (int i = 0; i < 22; i++) begin
         cpu_req = tbl[i].c_req; ld_req = tbl[i].l_req; ld_lock = tbl[i].lock;
         cycle();
         chk1($sformatf("tbl%0d_cpu_gnt", i), s_cpu_gnt, tbl[i].e_cg);
         chk1($sformatf("tbl%0d_ld_gnt", i), s_ld_gnt, tbl[i].e_lg);
         chk1($sformatf("tbl%0d_cpu_stall", i), s_cpu_stall, tbl[i].e_cst);
      end

      // Locked for 20 cycles, then release
      cpu_req = 1'b1; ld_req = 1'b1; ld_lock = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (s_cpu_gnt) cnt++;
         chk1("t4_locked_stall", s_cpu_stall, 1'b1);
      end
      chk16("t4_locked_cpu_gnts", 16'(cnt), 16'h0);
      ld_lock = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
         cycle();
         got = s_cpu_gnt;
      end
      chk1("t4_unlock_gnt_within_4", got, 1'b1);
      cpu_req = 1'b0; ld_req = 1'b0;
      cycle();
      cycle();

      // Reset in the middle of an LD write and an LD read
      ld_op(1'b1, 4'h2, 8'h11);
      cycle();
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 4'h2; ld_wdata = 8'h77;
      cycle();
      rst = 1'b1; ld_req = 1'b0;
      cycle();
      chk1("t5_reset_ram_we", s_ram_we, 1'b0);
      rst = 1'b0;
      cycle();
      chk1("t5_no_ld_rvalid", s_ld_rvalid, 1'b0);
      chk1("t5_idle_after", s_ld_gnt | s_cpu_gnt, 1'b0);
      cpu_op(1'b0, 4'h2, 8'h00);
      cycle();
      chk8("t5_ram2_kept", s_cpu_rdata, 8'h11);
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 4'h2;
      cycle();
      rst = 1'b1; ld_req = 1'b0;
      cycle();
      rst = 1'b0;
      cycle();
      chk1("t5_read_across_reset", s_ld_rvalid, 1'b0);

      // Random traffic against the model
      prev_any = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         if (g_cpu) cpu_req = 1'b0;
         if (g_ld)  ld_req  = 1'b0;
         if (cpu_req && $urandom_range(9) == 0) cpu_req = 1'b0;
         else if (!cpu_req && $urandom_range(9) < 4) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = 4'($urandom); cpu_wdata = 8'($urandom);
         end
         if (ld_req && $urandom_range(9) == 0) ld_req = 1'b0;
         else if (!ld_req && $urandom_range(9) < 4) begin
            ld_req = 1'b1; ld_we = 1'($urandom); ld_addr = 4'($urandom); ld_wdata = 8'($urandom);
         end
         if ($urandom_range(19) == 0) ld_lock = ~ld_lock;
         cycle();
         any_now = s_cpu_gnt | s_ld_gnt;
         chk1("gnt_spacing", any_now & prev_any, 1'b0);
         chk1("gnt_onehot", s_cpu_gnt & s_ld_gnt, 1'b0);
         prev_any = any_now;
      end
      cpu_req = 1'b0; ld_req = 1'b0; ld_lock = 1'b0;
      cycle();

`ifdef ARB_PERF_EN
      // Stall counting and saturation
      reset_cycle();
      cpu_req = 1'b1; cpu_we = 1'b0; ld_req = 1'b0; ld_lock = 1'b1;
      repeat (8) cycle();
      chk16("t6_wait_cnt_7", s_wait, 16'd7);
      repeat (70000 - 7) cycle();
      chk16("t6_wait_cnt_sat", s_wait, 16'hFFFF);
      cpu_req = 1'b0; ld_lock = 1'b0;
      cycle();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 16x8 program/data RAM between two requesters: the CPU control path (CPU port) and the external program loader/debug port (LD port).
- Serialises accesses through a small FSM and returns read data one cycle after the RAM access.
- Provides bounded-starvation priority and a loader lock for program-load mode.
- Drives `cpu_stall` so the control block can freeze its T-stage counter while the CPU waits.

Parameters:
- ADDR_W, 4, RAM address width
- DATA_W, 8, RAM data width
- LD_BURST_MAX, 3, consecutive contested LD grants before CPU is forced a grant; legal range 1..7

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held with command stable until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU command applied to RAM this cycle
- cpu_rvalid  out  1  one-cycle pulse, cycle after a CPU read grant
- cpu_rdata  out  DATA_W  read data, valid with cpu_rvalid
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- ld_req, ld_we, ld_addr, ld_wdata, ld_gnt, ld_rvalid, ld_rdata: same as CPU set, for the LD port
- ld_lock  in  1  while high, CPU is never granted
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data; valid the cycle after ram_en with ram_we=0

Behaviour:
- FSM states: IDLE, ACC_CPU, ACC_LD. All other encodings go to IDLE.
- IDLE: sample requests and pick a winner.
  - Only cpu_req: go to ACC_CPU.
  - Only ld_req: go to ACC_LD.
  - Both: ACC_LD, unless ld_lock=0 and streak==LD_BURST_MAX, then ACC_CPU.
  - cpu_req with ld_lock=1: never wins; stays IDLE if no ld_req.
  - No requests: stay IDLE.
- ACC_x (exactly one cycle):
  - x_gnt=1, ram_en=1.
  - ram_we, ram_addr and ram_wdata are combinational copies of port x's command.
  - Next state is always IDLE, so each access takes 2 cycles minimum.
- Read return:
  - x_rvalid is registered, high in the cycle after ACC_x with x_we=0.
  - x_rdata = ram_rdata in that cycle.
  - rdata holds its last value otherwise.
- Streak counter (3 bits):
  - Increments on an ACC_LD entered while cpu_req was high.
  - Clears on any ACC_CPU entry and on any IDLE cycle with cpu_req=0.
  - Saturates at LD_BURST_MAX.
- Idle outputs: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0 in IDLE.
- Reset (synchronous):
  - state=IDLE, streak=0.
  - All gnt/rvalid=0, rdata=0.
  - ram_en and ram_we are gated low combinationally in any cycle with rst=1, so a reset during ACC_x never writes RAM.
  - A read pending across reset returns no rvalid.
- A requester dropping req before its grant cancels the request, with no side effect.
- ld_lock rising while state=ACC_CPU: the in-flight CPU access completes; the lock takes effect at the next IDLE.
- Same address and same cycle from both ports: the winner is decided by the IDLE rules above; the loser sees stall only.

Optional Feature:
- ARB_PERF_EN defined:
  - Adds output `cpu_wait_cnt [15:0]`, counting cycles with cpu_stall=1. It saturates at 16'hFFFF and clears on rst.
  - Adds output `ld_grant_cnt [15:0]`, counting ld_gnt pulses. It saturates at 16'hFFFF and clears on rst.
- ARB_PERF_EN undefined: the ports and counters are absent; the remaining behaviour is identical.

Decomposition:
- Package `arb_pkg`:
  - FSM state encoding constants (IDLE=2'd0, ACC_CPU=2'd1, ACC_LD=2'd2).
  - Requester IDs REQ_CPU=1'b0, REQ_LD=1'b1.
  - Default widths.
- Sub-module `arb_sat_counter` (parameterised width, inc, clr, saturating):
  - Used for the streak counter.
  - Used for both perf counters when ARB_PERF_EN is set.

Test Plan:
1. Reset, then cpu_req=1, cpu_we=0, cpu_addr=4'h5, with RAM[5]=8'h3C → cpu_gnt at cycle 2; cpu_rvalid and cpu_rdata=8'h3C at cycle 3; cpu_stall=1 for cycle 1 only.
2. ld_req write to addr 4'hF, wdata 8'hA5, then CPU reads 4'hF → ram_we=1 only during ACC_LD; CPU read returns 8'hA5.
3. Both requesting continuously, LD_BURST_MAX=3, ld_lock=0 → grant order LD, LD, LD, CPU, LD, ...; no two grants are closer than 2 cycles.
4. ld_lock=1, both requesting for 20 cycles → zero cpu_gnt and cpu_stall=1 throughout. Drop the lock → cpu_gnt within 4 cycles.
5. rst asserted during ACC_LD write to 4'h2 (old value 8'h11) → ram_we=0 that cycle; RAM[2] stays 8'h11; no rvalid; state IDLE afterwards.
6. ARB_PERF_EN: CPU stalled for 7 cycles → cpu_wait_cnt=7. Force 70000 stall cycles → cpu_wait_cnt=16'hFFFF.
